// File: rtl/mrdo_sprite_scheduler.sv
// Per-scanline sprite scheduler: scans sprite RAM at hblank for sprites that
// intersect the next line, queues up to MAX_PER_LINE of them, then presents
// them one at a time to the bitmap fetcher over a req/ack handshake.
module mrdo_sprite_scheduler #(
    parameter int unsigned NUM_SPRITES  = 64,
    parameter int unsigned MAX_PER_LINE = 8,
    parameter int unsigned SPR_HEIGHT   = 16
) (
    input  logic       clk_sys_i,
    input  logic       reset_i,
    input  logic       ce_i,
    input  logic       hblank_start_i,
    input  logic [7:0] line_i,
    output logic [7:0] spr_addr_o,
    input  logic [7:0] spr_data_i,
    output logic       fetch_req_o,
    input  logic       fetch_ack_i,
    output logic [7:0] fetch_tile_o,
    output logic [3:0] fetch_row_o,
    output logic [7:0] fetch_color_o,
    output logic [7:0] fetch_x_o,
    output logic       busy_o,
    output logic       overflow_o,
    output logic [4:0] count_o
);
    localparam int unsigned SW       = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam logic [5:0]  LAST_IDX = 6'(NUM_SPRITES - 1);
    localparam logic [4:0]  MAX_CNT  = 5'(MAX_PER_LINE);
    localparam logic [7:0]  HEIGHT   = 8'(SPR_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN_ADDR, S_SCAN_Y, S_LOAD, S_FETCH, S_DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_line, w_line_nxt;
    logic [5:0] r_index, w_index_nxt;
    logic [4:0] r_count, w_count_nxt;
    logic [1:0] r_step, w_step_nxt;
    logic [4:0] r_k, w_k_nxt;
    logic       r_gap, w_gap_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_overflow, w_overflow_nxt;

    logic [7:0] r_tile  [MAX_PER_LINE];
    logic [3:0] r_row   [MAX_PER_LINE];
    logic [7:0] r_color [MAX_PER_LINE];
    logic [7:0] r_x     [MAX_PER_LINE];

    logic          w_wr_row, w_wr_tile, w_wr_color, w_wr_x;
    logic          w_start, w_hit, w_last, w_req;
    logic [7:0]    w_row;
    logic [SW-1:0] w_wslot, w_rslot;

    assign w_start = ce_i & hblank_start_i;
    assign w_row   = r_line - spr_data_i;
    assign w_hit   = (spr_data_i != 8'd0) && (w_row < HEIGHT);
    assign w_last  = (r_index == LAST_IDX);
    assign w_wslot = r_count[SW-1:0];
    assign w_rslot = r_k[SW-1:0];
    // hblank pulls req down combinationally so an abort never looks like an ack
    assign w_req   = (r_state == S_FETCH) && !r_gap && !w_start;

    // Next-state and datapath control; hblank restarts from any state
    always_comb begin
        w_state_nxt    = r_state;
        w_line_nxt     = r_line;
        w_index_nxt    = r_index;
        w_count_nxt    = r_count;
        w_step_nxt     = r_step;
        w_k_nxt        = r_k;
        w_gap_nxt      = r_gap;
        w_busy_nxt     = r_busy;
        w_overflow_nxt = r_overflow;
        w_wr_row       = 1'b0;
        w_wr_tile      = 1'b0;
        w_wr_color     = 1'b0;
        w_wr_x         = 1'b0;
        if (w_start) begin
            w_state_nxt    = S_SCAN_ADDR;
            w_line_nxt     = line_i;
            w_index_nxt    = '0;
            w_count_nxt    = '0;
            w_step_nxt     = '0;
            w_k_nxt        = '0;
            w_gap_nxt      = 1'b0;
            w_busy_nxt     = 1'b1;
            w_overflow_nxt = 1'b0;
        end else begin
            case (r_state)
                S_SCAN_ADDR: w_state_nxt = S_SCAN_Y;
                S_SCAN_Y: begin
                    if (w_hit && (r_count < MAX_CNT)) begin
                        w_wr_row    = 1'b1;
                        w_step_nxt  = '0;
                        w_state_nxt = S_LOAD;
                    end else if (w_hit) begin
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = S_FETCH;
                    end else if (w_last) begin
                        w_state_nxt = (r_count == 5'd0) ? S_DONE : S_FETCH;
                    end else begin
                        w_index_nxt = r_index + 6'd1;
                        w_state_nxt = S_SCAN_ADDR;
                    end
                end
                S_LOAD: begin
                    w_step_nxt = r_step + 2'd1;
                    case (r_step)
                        2'd0: ;
                        2'd1: w_wr_tile  = 1'b1;
                        2'd2: w_wr_color = 1'b1;
                        default: begin
                            w_wr_x      = 1'b1;
                            w_count_nxt = r_count + 5'd1;
                            if (w_last) begin
                                w_state_nxt = S_FETCH;
                            end else begin
                                w_index_nxt = r_index + 6'd1;
                                w_state_nxt = S_SCAN_ADDR;
                            end
                        end
                    endcase
                end
                S_FETCH: begin
                    if (r_gap) begin
                        w_gap_nxt = 1'b0;
                    end else if (fetch_ack_i) begin
                        if (r_k + 5'd1 == r_count) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_k_nxt   = r_k + 5'd1;
                            w_gap_nxt = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else if (ce_i) begin
            r_state <= w_state_nxt;
        end
    end

    // Scan/fetch bookkeeping registers
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            r_line     <= '0;
            r_index    <= '0;
            r_count    <= '0;
            r_step     <= '0;
            r_k        <= '0;
            r_gap      <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (ce_i) begin
            r_line     <= w_line_nxt;
            r_index    <= w_index_nxt;
            r_count    <= w_count_nxt;
            r_step     <= w_step_nxt;
            r_k        <= w_k_nxt;
            r_gap      <= w_gap_nxt;
            r_busy     <= w_busy_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Queue slots, filled field by field as sprite RAM bytes arrive
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < MAX_PER_LINE; i++) begin
                r_tile[i]  <= '0;
                r_row[i]   <= '0;
                r_color[i] <= '0;
                r_x[i]     <= '0;
            end
        end else if (ce_i) begin
            if (w_wr_row)   r_row[w_wslot]   <= w_row[3:0];
            if (w_wr_tile)  r_tile[w_wslot]  <= spr_data_i;
            if (w_wr_color) r_color[w_wslot] <= spr_data_i;
            if (w_wr_x)     r_x[w_wslot]     <= spr_data_i;
        end
    end

    // Sprite RAM address: y byte while scanning, then tile/colour/x while loading
    always_comb begin
        spr_addr_o = '0;
        case (r_state)
            S_SCAN_ADDR, S_SCAN_Y: spr_addr_o = {r_index, 2'b01};
            S_LOAD: begin
                case (r_step)
                    2'd0:    spr_addr_o = {r_index, 2'b00};
                    2'd1:    spr_addr_o = {r_index, 2'b10};
                    default: spr_addr_o = {r_index, 2'b11};
                endcase
            end
            default: ;
        endcase
    end

    assign fetch_req_o   = w_req;
    assign fetch_tile_o  = w_req ? r_tile[w_rslot]  : '0;
    assign fetch_row_o   = w_req ? r_row[w_rslot]   : '0;
    assign fetch_color_o = w_req ? r_color[w_rslot] : '0;
    assign fetch_x_o     = w_req ? r_x[w_rslot]     : '0;
    assign busy_o        = r_busy;
    assign overflow_o    = r_overflow;
    assign count_o       = r_count;
endmodule

// File: tb/tb_mrdo_sprite_scheduler.sv
// Bench for mrdo_sprite_scheduler: sprite RAM model with one-ce read latency,
// a per-line reference model of hits/overflow/scan time, and a cycle monitor.
module tb_mrdo_sprite_scheduler;
    logic       clk = 1'b0;
    logic       reset_i, ce_i, hblank_start_i, fetch_ack_i;
    logic [7:0] line_i;
    logic [7:0] spr_data_i = 8'd0;
    logic [7:0] spr_addr_o, fetch_tile_o, fetch_color_o, fetch_x_o;
    logic [3:0] fetch_row_o;
    logic       fetch_req_o, busy_o, overflow_o;
    logic [4:0] count_o;

    logic [7:0] ram [256];
    int n_cmp = 0;
    int n_bad = 0;

    // reference model results for the current line
    int exp_n, exp_ovf, exp_scan;
    logic [7:0] e_tile [16], e_color [16], e_x [16];
    logic [3:0] e_row [16];
    // fields actually accepted from the DUT in the last run
    logic [7:0] a_tile [16], a_color [16], a_x [16];
    logic [3:0] a_row [16];
    int a_n, m_scan;

    always #5 clk = ~clk;

    mrdo_sprite_scheduler #(.NUM_SPRITES(64), .MAX_PER_LINE(8), .SPR_HEIGHT(16)) dut (
        .clk_sys_i(clk), .reset_i(reset_i), .ce_i(ce_i),
        .hblank_start_i(hblank_start_i), .line_i(line_i),
        .spr_addr_o(spr_addr_o), .spr_data_i(spr_data_i),
        .fetch_req_o(fetch_req_o), .fetch_ack_i(fetch_ack_i),
        .fetch_tile_o(fetch_tile_o), .fetch_row_o(fetch_row_o),
        .fetch_color_o(fetch_color_o), .fetch_x_o(fetch_x_o),
        .busy_o(busy_o), .overflow_o(overflow_o), .count_o(count_o)
    );

    // synchronous sprite RAM: data follows the address one ce cycle later
    always @(posedge clk) if (ce_i) spr_data_i <= ram[spr_addr_o];

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, got, got, want, want);
        end
    endtask

    // Which sprites hit line L, in index order, and how many ce cycles the scan takes
    task automatic model(input logic [7:0] L);
        logic [7:0] y, row;
        exp_n = 0; exp_ovf = 0; exp_scan = 0;
        for (int i = 0; i < 64; i++) begin
            y = ram[i*4+1];
            row = L - y;
            exp_scan += 2;
            if (y != 8'd0 && row < 8'd16) begin
                if (exp_n == 8) begin
                    exp_ovf = 1;
                    break;
                end
                e_tile[exp_n]  = ram[i*4];
                e_row[exp_n]   = row[3:0];
                e_color[exp_n] = ram[i*4+2];
                e_x[exp_n]     = ram[i*4+3];
                exp_n++;
                exp_scan += 4;
            end
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram[i] = 8'd0;
    endtask

    task automatic set_spr(input int idx, input logic [7:0] t, input logic [7:0] y,
                           input logic [7:0] c, input logic [7:0] x);
        ram[idx*4] = t; ram[idx*4+1] = y; ram[idx*4+2] = c; ram[idx*4+3] = x;
    endtask

    // Run one line; ack_delay<0 means random ack, abort_k>=0 restarts with L2 while slot abort_k is offered
    task automatic run_line(input logic [7:0] L, input int ce_rand, input int ack_delay,
                            input int abort_k, input logic [7:0] L2, input string tag);
        int kk, scan, eg, held, cyc;
        bit seen, done, ce_n, ack_n;
        model(L);
        @(negedge clk);
        line_i = L; hblank_start_i = 1'b1; ce_i = 1'b1; fetch_ack_i = 1'b0;
        @(negedge clk);
        hblank_start_i = 1'b0;
        kk = 0; scan = 0; eg = 0; held = 0; cyc = 0; seen = 0; done = 0;
        while (!done) begin
            if (!busy_o) begin
                chk({tag, "_fetches"}, kk, exp_n);
                chk({tag, "_count"}, int'(count_o), exp_n);
                chk({tag, "_overflow"}, int'(overflow_o), exp_ovf);
                chk({tag, "_scan_cycles"}, scan, exp_scan + ((exp_n == 0) ? 1 : 0));
                m_scan = scan; a_n = kk;
                done = 1;
            end else if (cyc > 4000) begin
                chk({tag, "_timeout"}, cyc, 0);
                a_n = kk;
                done = 1;
            end else begin
                if (fetch_req_o) begin
                    if (kk < exp_n) begin
                        chk({tag, "_tile"},  int'(fetch_tile_o),  int'(e_tile[kk]));
                        chk({tag, "_row"},   int'(fetch_row_o),   int'(e_row[kk]));
                        chk({tag, "_color"}, int'(fetch_color_o), int'(e_color[kk]));
                        chk({tag, "_x"},     int'(fetch_x_o),     int'(e_x[kk]));
                    end else begin
                        chk({tag, "_spurious_req"}, 1, 0);
                    end
                    seen = 1;
                end
                if (eg == 1) chk({tag, "_gap_low"}, int'(fetch_req_o), 0);
                if (eg == 2 && kk < exp_n) chk({tag, "_gap_next"}, int'(fetch_req_o), 1);
                if (abort_k >= 0 && fetch_req_o && kk == abort_k) begin
                    model(L2);
                    line_i = L2; hblank_start_i = 1'b1; ce_i = 1'b1; fetch_ack_i = 1'b1;
                    #1;
                    chk({tag, "_abort_req_drop"}, int'(fetch_req_o), 0);
                    @(negedge clk);
                    hblank_start_i = 1'b0; fetch_ack_i = 1'b0;
                    kk = 0; scan = 0; eg = 0; held = 0; seen = 0; abort_k = -1;
                end else begin
                    ce_n = (ce_rand != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
                    if (ack_delay < 0) ack_n = ($urandom_range(0, 1) == 1);
                    else ack_n = fetch_req_o && (held >= ack_delay);
                    ce_i = ce_n; fetch_ack_i = ack_n;
                    if (!seen && !fetch_req_o && ce_n) scan++;
                    if (ce_n) begin
                        if (fetch_req_o && ack_n) begin
                            a_tile[kk] = fetch_tile_o; a_row[kk] = fetch_row_o;
                            a_color[kk] = fetch_color_o; a_x[kk] = fetch_x_o;
                            kk++; eg = 1; held = 0;
                        end else begin
                            if (fetch_req_o) held++;
                            if (eg > 0 && eg < 3) eg++;
                        end
                    end
                    @(negedge clk);
                end
            end
            cyc++;
        end
        // results hold while idle, ack ignored
        for (int i = 0; i < 3; i++) begin
            ce_i = ($urandom_range(0, 1) == 1); fetch_ack_i = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            chk({tag, "_hold_count"}, int'(count_o), exp_n);
            chk({tag, "_hold_req"}, int'(fetch_req_o), 0);
        end
        ce_i = 1'b1; fetch_ack_i = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; ce_i = 1'b0; hblank_start_i = 1'b0; line_i = 8'd0; fetch_ack_i = 1'b0;
        clear_ram();
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_req", int'(fetch_req_o), 0);
        chk("reset_count", int'(count_o), 0);
        chk("reset_overflow", int'(overflow_o), 0);
        chk("reset_addr", int'(spr_addr_o), 0);
        chk("reset_tile", int'(fetch_tile_o), 0);
        reset_i = 1'b0; ce_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy_o), 0);

        run_line(8'h47, 0, 0, -1, 8'h00, "allzero");
        chk("pin_allzero_busy_cycles", m_scan, 129);

        set_spr(5, 8'h3A, 8'h40, 8'h07, 8'h80);
        run_line(8'h47, 0, 0, -1, 8'h00, "spr5");
        chk("pin_spr5_n", a_n, 1);
        chk("pin_spr5_tile", int'(a_tile[0]), 8'h3A);
        chk("pin_spr5_row", int'(a_row[0]), 7);
        chk("pin_spr5_color", int'(a_color[0]), 8'h07);
        chk("pin_spr5_x", int'(a_x[0]), 8'h80);
        chk("pin_spr5_ovf", int'(overflow_o), 0);

        set_spr(12, 8'h55, 8'hF8, 8'h01, 8'h02);
        run_line(8'h03, 0, 0, -1, 8'h00, "wrap");
        chk("pin_wrap_n", a_n, 1);
        chk("pin_wrap_row", int'(a_row[0]), 11);
        chk("pin_wrap_tile", int'(a_tile[0]), 8'h55);
        run_line(8'h50, 0, 0, -1, 8'h00, "row16");
        chk("pin_row16_n", a_n, 0);
        run_line(8'h4F, 0, 0, -1, 8'h00, "row15");
        chk("pin_row15_row", int'(a_row[0]), 15);

        clear_ram();
        for (int i = 0; i < 10; i++)
            set_spr(i, 8'(8'h10 + i), 8'h20, 8'(i), 8'(8'h30 + i));
        run_line(8'h20, 0, 0, -1, 8'h00, "ovf");
        chk("pin_ovf_n", a_n, 8);
        chk("pin_ovf_count", int'(count_o), 8);
        chk("pin_ovf_flag", int'(overflow_o), 1);
        chk("pin_ovf_first_tile", int'(a_tile[0]), 8'h10);
        chk("pin_ovf_last_tile", int'(a_tile[7]), 8'h17);
        chk("pin_ovf_scan", m_scan, 50);
        run_line(8'h20, 0, 5, -1, 8'h00, "handshake");
        run_line(8'h20, 1, 2, -1, 8'h00, "ce_toggle");

        // reset in the middle of a scan
        @(negedge clk);
        line_i = 8'h20; hblank_start_i = 1'b1;
        @(negedge clk);
        hblank_start_i = 1'b0;
        repeat (20) @(negedge clk);
        reset_i = 1'b1; ce_i = 1'b0;
        @(negedge clk);
        chk("midreset_busy", int'(busy_o), 0);
        chk("midreset_count", int'(count_o), 0);
        chk("midreset_addr", int'(spr_addr_o), 0);
        reset_i = 1'b0; ce_i = 1'b1;

        clear_ram();
        set_spr(3,  8'hA3, 8'h60, 8'h13, 8'h23);
        set_spr(10, 8'hAA, 8'h60, 8'h1A, 8'h2A);
        set_spr(20, 8'hB4, 8'h60, 8'h14, 8'h24);
        set_spr(30, 8'hBE, 8'h60, 8'h1E, 8'h2E);
        set_spr(40, 8'hC0, 8'h90, 8'h20, 8'h40);
        set_spr(50, 8'hC1, 8'h90, 8'h21, 8'h41);
        run_line(8'h65, 0, 3, 2, 8'h95, "abort");
        chk("pin_abort_n", a_n, 2);
        chk("pin_abort_count", int'(count_o), 2);
        chk("pin_abort_tile0", int'(a_tile[0]), 8'hC0);
        chk("pin_abort_row1", int'(a_row[1]), 5);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 64; i++) begin
                set_spr(i, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                        8'($urandom), 8'($urandom));
            end
            if (r == 3)
                run_line(8'($urandom), r % 2, -1, 1, 8'($urandom), "rand_abort");
            else
                run_line(8'($urandom), r % 2, -1, -1, 8'h00, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
